// File: rtl/amo_unit.sv
// amo_unit: LR.W/SC.W/AMO*.W responder with reservation register over a single-outstanding req/ack memory port
module amo_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_lr,
  input  logic            is_sc,
  input  logic            is_amo,
  input  logic [4:0]      amo_funct5,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            invalidate,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            misaligned,
  output logic            resv_valid,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state, state_n;
  logic op_lr, op_sc, mis, sc_ok, accept, rd_ack, wr_ack;
  logic [4:0] funct5_q;
  logic [XLEN-1:0] rs2_q, old_q, amo_val;
  logic [XLEN-3:0] resv_addr;
  assign accept = state == IDLE && start;
  assign mis = |addr[1:0];
  assign sc_ok = resv_valid && resv_addr == addr[XLEN-1:2] && !invalidate;
  assign rd_ack = state == READ && mem_ack;
  assign wr_ack = state == WRITE && mem_ack;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE  ? (!start ? IDLE : mis ? DONE : (is_lr || is_amo) ? READ : sc_ok ? WRITE : DONE)
            : state == READ  ? (!mem_ack ? READ : op_lr ? DONE : WRITE)
            : state == WRITE ? (mem_ack ? DONE : WRITE)
            : IDLE;
  end
  always_comb begin
    amo_val = rs2_q;
    case (funct5_q)
      5'b00000: amo_val = mem_rdata + rs2_q;
      5'b00100: amo_val = mem_rdata ^ rs2_q;
      5'b01100: amo_val = mem_rdata & rs2_q;
      5'b01000: amo_val = mem_rdata | rs2_q;
      5'b10000: amo_val = $signed(mem_rdata) < $signed(rs2_q) ? mem_rdata : rs2_q;
      5'b10100: amo_val = $signed(mem_rdata) > $signed(rs2_q) ? mem_rdata : rs2_q;
      5'b11000: amo_val = mem_rdata < rs2_q ? mem_rdata : rs2_q;
      5'b11100: amo_val = mem_rdata > rs2_q ? mem_rdata : rs2_q;
      default:  amo_val = rs2_q;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_lr      <= 1'b0;
      op_sc      <= 1'b0;
      funct5_q   <= '0;
      rs2_q      <= '0;
      old_q      <= '0;
      result     <= '0;
      misaligned <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if (accept) begin
        op_lr      <= is_lr;
        op_sc      <= is_sc;
        funct5_q   <= amo_funct5;
        rs2_q      <= rs2_data;
        misaligned <= mis;
        mem_addr   <= {addr[XLEN-1:2], 2'b00};
        mem_wdata  <= rs2_data;
        mem_req    <= !mis && (is_lr || is_amo || sc_ok);
        mem_we     <= !mis && is_sc && sc_ok;
        if (mis || (is_sc && !sc_ok)) result <= mis ? '0 : XLEN'(1);
      end
      if (rd_ack) begin
        old_q     <= mem_rdata;
        mem_req   <= !op_lr;
        mem_we    <= !op_lr;
        mem_wdata <= amo_val;
        if (op_lr) result <= mem_rdata;
      end
      if (wr_ack) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        result  <= op_sc ? '0 : old_q;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      resv_valid <= 1'b0;
      resv_addr  <= '0;
    end else if (invalidate) resv_valid <= 1'b0;
    else if (rd_ack && op_lr) begin
      resv_valid <= 1'b1;
      resv_addr  <= mem_addr[XLEN-1:2];
    end else if (accept && is_sc && !mis) resv_valid <= 1'b0;
    else if (wr_ack && !op_sc && mem_addr[XLEN-1:2] == resv_addr) resv_valid <= 1'b0;
endmodule

// File: tb/tb_amo_unit.sv
// tb_amo_unit: scoreboard bench for amo_unit with a wait-state memory model
module tb_amo_unit;
  logic        clk = 0, rst = 1, start = 0, is_lr = 0, is_sc = 0, is_amo = 0, invalidate = 0;
  logic [4:0]  amo_funct5 = 0;
  logic [31:0] addr = 0, rs2_data = 0, result, mem_addr, mem_wdata, mem_rdata;
  logic        busy, done, misaligned, resv_valid, mem_req, mem_we, mem_ack;
  logic [31:0] mem [0:255];
  logic [32:0] exp_q [$];
  logic [63:0] wr_q [$];
  logic [32:0] e;
  logic [64:0] ph;
  logic        in_phase = 0;
  int tests = 0, fails = 0, cnt = 0, lat_cfg = 0, wr_cnt = 0, req_cyc = 0;
  int lat, r0, w0, n;

  amo_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_lr(is_lr), .is_sc(is_sc), .is_amo(is_amo),
    .amo_funct5(amo_funct5), .addr(addr), .rs2_data(rs2_data), .invalidate(invalidate),
    .busy(busy), .done(done), .result(result), .misaligned(misaligned), .resv_valid(resv_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  assign mem_ack = mem_req && cnt == lat_cfg;
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk or posedge rst)
    if (rst) cnt <= 0;
    else cnt <= (mem_req && !mem_ack) ? cnt + 1 : 0;

  task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL done_unexpected: got result %h expected no completion", result);
      end else begin
        e = exp_q.pop_front();
        check("result", {misaligned, result}, e);
      end
    end
    if (mem_req && mem_we && mem_ack) begin
      wr_cnt++;
      mem[mem_addr[9:2]] = mem_wdata;
      if (wr_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL write_unexpected: got %h <= %h expected no write", mem_addr, mem_wdata);
      end else check("write", {mem_addr, mem_wdata}, wr_q.pop_front());
    end
    if (mem_req) req_cyc++;
    if (mem_req && in_phase) check("req_stable", {mem_we, mem_addr, mem_wdata}, ph);
    in_phase = mem_req && !mem_ack;
    ph = {mem_we, mem_addr, mem_wdata};
  end

  task automatic issue(input logic lr, sc, amo, input logic [4:0] f5, input logic [31:0] a, d,
                       input logic inv, input logic [31:0] er, input logic em, output int l);
    exp_q.push_back({em, er});
    @(posedge clk); #1;
    start = 1; is_lr = lr; is_sc = sc; is_amo = amo; amo_funct5 = f5; addr = a; rs2_data = d; invalidate = inv;
    @(posedge clk); #1;
    start = 0; is_lr = 0; is_sc = 0; is_amo = 0; invalidate = 0;
    l = 1;
    while (!done && l < 40) begin @(posedge clk); #1; l++; end
    if (!done) begin
      tests++; fails++;
      $display("FAIL timeout: got no done after %0d cycles expected done", l);
    end
  endtask

  logic [4:0]  f5_t [10] = '{5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b00100,
                             5'b01100, 5'b01000, 5'b10100, 5'b00001, 5'b00010};
  logic [31:0] wd_t [10] = '{32'h0, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFE,
                             32'h1, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h1};

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'hDEAD0001;
    for (int i = 0; i < 10; i++) mem[8'h80 + i] = 32'hFFFFFFFF;
    mem[8'hC0] = 32'h12345678;
    #2;
    check("rst_outs", {busy, done, misaligned, resv_valid, mem_req, mem_we}, 0);
    check("rst_data", {result, mem_addr, mem_wdata}, 0);
    @(posedge clk); #1; rst = 0;

    r0 = req_cyc;
    issue(0, 1, 0, 0, 32'h100, 32'h77, 0, 32'h1, 0, lat);
    check("sc_nolr_lat", lat, 1);
    check("sc_nolr_noreq", req_cyc - r0, 0);

    issue(1, 0, 0, 0, 32'h100, 0, 0, 32'hDEAD0001, 0, lat);
    check("lr_lat", lat, 2);
    check("lr_resv", resv_valid, 1);

    wr_q.push_back({32'h100, 32'h55});
    issue(0, 1, 0, 0, 32'h100, 32'h55, 0, 32'h0, 0, lat);
    check("sc_ok_lat", lat, 2);
    check("sc_ok_resv", resv_valid, 0);
    check("sc_ok_mem", mem[8'h40], 32'h55);

    issue(1, 0, 0, 0, 32'h100, 0, 0, 32'h55, 0, lat);
    w0 = wr_cnt;
    issue(0, 1, 0, 0, 32'h104, 32'h9, 0, 32'h1, 0, lat);
    check("sc_addr_nowrite", wr_cnt - w0, 0);
    check("sc_addr_resv", resv_valid, 0);

    issue(1, 0, 0, 0, 32'h100, 0, 0, 32'h55, 0, lat);
    @(posedge clk); #1; invalidate = 1;
    @(posedge clk); #1; invalidate = 0;
    check("inv_clear", resv_valid, 0);
    issue(0, 1, 0, 0, 32'h100, 32'h9, 0, 32'h1, 0, lat);

    issue(1, 0, 0, 0, 32'h100, 0, 0, 32'h55, 0, lat);
    check("inv_same_pre", resv_valid, 1);
    w0 = wr_cnt;
    issue(0, 1, 0, 0, 32'h100, 32'h9, 1, 32'h1, 0, lat);
    check("inv_same_nowrite", wr_cnt - w0, 0);

    for (int i = 0; i < 10; i++) begin
      wr_q.push_back({32'h200 + 32'(4 * i), wd_t[i]});
      issue(0, 0, 1, f5_t[i], 32'h200 + 32'(4 * i), 32'h1, 0, 32'hFFFFFFFF, 0, lat);
      check("amo_lat", lat, 3);
    end

    r0 = req_cyc;
    issue(1, 0, 0, 0, 32'h102, 0, 0, 32'h0, 1, lat);
    check("mis_lat", lat, 1);
    check("mis_noreq", req_cyc - r0, 0);

    lat_cfg = 2;
    wr_q.push_back({32'h300, 32'hCAFEBABE});
    issue(0, 0, 1, 5'b00001, 32'h300, 32'hCAFEBABE, 0, 32'h12345678, 0, lat);
    check("wait_lat", lat, 7);
    lat_cfg = 0;

    issue(1, 0, 0, 0, 32'h100, 0, 0, 32'h55, 0, lat);
    wr_q.push_back({32'h100, 32'h56});
    issue(0, 0, 1, 5'b00000, 32'h100, 32'h1, 0, 32'h55, 0, lat);
    check("amo_clr_resv", resv_valid, 0);

    issue(1, 0, 0, 0, 32'h100, 0, 0, 32'h56, 0, lat);
    lat_cfg = 3;
    @(posedge clk); #1;
    start = 1; is_amo = 1; amo_funct5 = 5'b00001; addr = 32'h280; rs2_data = 32'h1;
    @(posedge clk); #1;
    start = 0; is_amo = 0;
    n = 0;
    while (!(mem_req && mem_we) && n < 20) begin @(posedge clk); #1; n++; end
    check("reach_write", {mem_req, mem_we}, 2'b11);
    check("pre_rst_resv", resv_valid, 1);
    rst = 1; #1;
    check("rst_mid_req", mem_req, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_resv", resv_valid, 0);
    @(posedge clk); #1; rst = 0; lat_cfg = 0;
    issue(1, 0, 0, 0, 32'h100, 0, 0, 32'h56, 0, lat);
    check("post_rst_lat", lat, 2);
    check("post_rst_resv", resv_valid, 1);

    @(posedge clk); #1;
    check("queues_empty", exp_q.size() + wr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
